// File: rtl/compress_pkg.sv
// Shared types for the dictionary instruction compressor: FSM state
// encoding and the position of the hit flag in a default-width token.
package compress_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_EMIT   = 2'd2
  } state_e;

  // Token bit WIDTH carries the hit flag; for the default 32-bit instruction that is bit 32.
  localparam int HIT_BIT = 32;

endpackage

// File: rtl/comparator.sv
// Plain WIDTH-bit equality comparator shared by the compressor datapath.
module comparator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/instr_compressor.sv
// Dictionary-based instruction compressor: walks the dictionary one entry per
// cycle and emits either a hit token (index) or a miss token (raw instruction).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | ready for an instruction; dictionary writes accepted
// S_SEARCH | comparing dict[idx] against the captured instruction
// S_EMIT   | token on out_data, waiting for out_ready
module instr_compressor
  import compress_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int DICT_SIZE = 16,
  localparam int IDX_W     = $clog2(DICT_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             dict_we,
  input  logic [IDX_W-1:0] dict_addr,
  input  logic [WIDTH-1:0] dict_wdata,
  output logic             out_valid,
  output logic [WIDTH:0]   out_data,
  input  logic             out_ready,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     instr_q, instr_d;
  logic [WIDTH:0]       out_data_q, out_data_d;
  logic [15:0]          hit_q, hit_d;
  logic [15:0]          miss_q, miss_d;

  logic [WIDTH-1:0]     dict_q [DICT_SIZE];
  logic [DICT_SIZE-1:0] dict_vld_q;

  logic dict_wr;
  logic cmp_eq;
  logic match;
  logic last_idx;

  assign dict_wr  = dict_we && (state_q == S_IDLE);
  assign match    = cmp_eq && dict_vld_q[idx_q];
  assign last_idx = (idx_q == IDX_W'(DICT_SIZE - 1));

  comparator #(.WIDTH(WIDTH)) u_cmp (
    .a_i  (dict_q[idx_q]),
    .b_i  (instr_q),
    .eq_o (cmp_eq)
  );

  // Entry data is intentionally not reset; the valid bits gate every compare.
  always_ff @(posedge clk) begin
    if (dict_wr) dict_q[dict_addr] <= dict_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dict_vld_q <= '0;
    end else if (dict_wr) begin
      dict_vld_q[dict_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      instr_q    <= '0;
      out_data_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      instr_q    <= instr_d;
      out_data_q <= out_data_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    instr_d    = instr_q;
    out_data_d = out_data_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          instr_d = in_data;
          idx_d   = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        // Ascending walk with early exit makes the lowest matching index win.
        if (match) begin
          out_data_d             = '0;
          out_data_d[WIDTH]      = 1'b1;
          out_data_d[IDX_W-1:0]  = idx_q;
          state_d                = S_EMIT;
        end else if (last_idx) begin
          out_data_d = {1'b0, instr_q};
          state_d    = S_EMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          if (out_data_q[WIDTH]) hit_d  = hit_q + 16'd1;
          else                   miss_d = miss_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_EMIT);
  assign out_data   = out_data_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_instr_compressor.sv
// Randomised self-checking bench for instr_compressor against a
// dictionary-lookup reference model.
module tb_instr_compressor;
  import compress_pkg::*;

  localparam int WIDTH = 32;
  localparam int DS    = 16;
  localparam int IW    = $clog2(DS);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             dict_we;
  logic [IW-1:0]    dict_addr;
  logic [WIDTH-1:0] dict_wdata;
  logic             out_valid;
  logic [WIDTH:0]   out_data;
  logic             out_ready;
  logic [15:0]      hit_count;
  logic [15:0]      miss_count;

  instr_compressor #(.WIDTH(WIDTH), .DICT_SIZE(DS)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .dict_we    (dict_we),
    .dict_addr  (dict_addr),
    .dict_wdata (dict_wdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // reference model
  logic [WIDTH-1:0] m_dict [DS];
  bit               m_vld  [DS];
  logic [15:0]      m_hits, m_misses;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DS; i++) m_vld[i] = 0;
    m_hits   = '0;
    m_misses = '0;
  endtask

  task automatic model_write(input int addr, input logic [WIDTH-1:0] data);
    m_dict[addr] = data;
    m_vld[addr]  = 1;
  endtask

  // Lowest valid matching index, or -1 on a miss.
  function automatic int model_lookup(input logic [WIDTH-1:0] v);
    for (int i = 0; i < DS; i++)
      if (m_vld[i] && m_dict[i] == v) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dict_write(input int addr, input logic [WIDTH-1:0] data);
    dict_we    = 1'b1;
    dict_addr  = IW'(addr);
    dict_wdata = data;
    tick();
    dict_we = 1'b0;
    model_write(addr, data);
  endtask

  // mode 0: plain send; 1: dictionary write in the accept cycle;
  // 2: dictionary write attempted during the search (must be dropped)
  task automatic send(input logic [WIDTH-1:0] val, input int stall, input int mode,
                      input int waddr, input logic [WIDTH-1:0] wdata);
    int          k;
    int          exp_lat;
    logic [63:0] exp_tok;
    int          lat;
    bit          got;
    in_valid  = 1'b1;
    in_data   = val;
    out_ready = 1'b0;
    if (mode == 1) begin
      dict_we    = 1'b1;
      dict_addr  = IW'(waddr);
      dict_wdata = wdata;
      model_write(waddr, wdata);
    end
    k = model_lookup(val);
    if (k >= 0) begin
      exp_lat = k + 1;
      exp_tok = (64'd1 << HIT_BIT) | 64'(k);
    end else begin
      exp_lat = DS;
      exp_tok = 64'(val);
    end
    tick();
    in_valid = 1'b0;
    dict_we  = 1'b0;
    check("in_ready_after_accept", 64'(in_ready), 64'd0);
    if (mode == 2) begin
      dict_we    = 1'b1;
      dict_addr  = IW'(waddr);
      dict_wdata = wdata;
    end
    lat = 0;
    got = 0;
    while (!got && lat < DS + 8) begin
      tick();
      dict_we = 1'b0;
      lat++;
      if (out_valid) got = 1;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("token", 64'(out_data), exp_tok);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("hold_token", 64'(out_data), exp_tok);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("busy_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (k >= 0) m_hits++;
    else        m_misses++;
    check("valid_after_hs", 64'(out_valid), 64'd0);
    check("ready_after_hs", 64'(in_ready), 64'd1);
    check("hit_count", 64'(hit_count), 64'(m_hits));
    check("miss_count", 64'(miss_count), 64'(m_misses));
  endtask

  logic [WIDTH-1:0] pool [8];

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    dict_we    = 1'b0;
    dict_addr  = '0;
    dict_wdata = '0;
    out_ready  = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 15) begin
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_hits", 64'(hit_count), 64'd0);
        check("idle_misses", 64'(miss_count), 64'd0);
        check("idle_out_data", 64'(out_data), 64'd0);
      end
    end

    // directed cases
    dict_write(3, 32'hE3A00001);
    send(32'hE3A00001, 0, 0, 0, '0);
    check("dir_hit_count", 64'(hit_count), 64'd1);
    send(32'hDEADBEEF, 0, 0, 0, '0);
    check("dir_miss_count", 64'(miss_count), 64'd1);
    dict_write(2, 32'h12345678);
    dict_write(9, 32'h12345678);
    send(32'h12345678, 5, 0, 0, '0);
    send(32'hCAFE0005, 1, 2, 5, 32'hCAFE0005);
    send(32'hCAFE0005, 0, 0, 0, '0);
    send(32'hA5A50F0F, 0, 1, 15, 32'hA5A50F0F);
    send(32'hA5A50F0F, 2, 1, 0, 32'hA5A50F0F);

    // reset in the middle of a search
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("async_rst_ready", 64'(in_ready), 64'd1);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    model_reset();
    tick();
    reset = 1'b0;
    for (int i = 0; i < DS + 4; i++) begin
      tick();
      if (out_valid) check("no_token_after_rst", 64'(out_valid), 64'd0);
    end
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_hits", 64'(hit_count), 64'd0);
    check("rst_misses", 64'(miss_count), 64'd0);
    send(32'h12345678, 0, 0, 0, '0);

    // randomised traffic
    for (int i = 0; i < 8; i++) pool[i] = $urandom;
    for (int t = 0; t < 60; t++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 3) begin
        dict_write(int'($urandom_range(0, DS - 1)), pool[$urandom_range(0, 7)]);
      end else if (op < 8) begin
        send(pool[$urandom_range(0, 7)], int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, DS - 1)),
             pool[$urandom_range(0, 7)]);
      end else begin
        send($urandom, int'($urandom_range(0, 2)), 0, 0, '0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_compressor.md
INSTR_COMPRESSOR -- requirements
Module: instr_compressor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction width in bits.
REQ-002 SHALL have parameter DICT_SIZE, default 16, dictionary entry count; a power of 2, at least 2.
REQ-003 SHALL have derived localparam IDX_W = $clog2(DICT_SIZE).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  instruction present.
REQ-007 in_data  input  WIDTH  uncompressed instruction.
REQ-008 in_ready  output  1  block can accept an instruction.
REQ-009 dict_we  input  1  dictionary write strobe.
REQ-010 dict_addr  input  IDX_W  dictionary write index.
REQ-011 dict_wdata  input  WIDTH  dictionary entry value.
REQ-012 out_valid  output  1  token present.
REQ-013 out_data  output  WIDTH+1  token; bit WIDTH is the hit flag.
REQ-014 out_ready  input  1  downstream decompressor accepts token.
REQ-015 hit_count, miss_count  output  16 each  wrapping token statistics.

Function
REQ-016 SHALL implement FSM states IDLE, SEARCH, EMIT.
REQ-017 IDLE: in_ready=1; on in_valid, capture in_data, clear idx to 0, go to SEARCH.
REQ-018 SEARCH: compare dict[idx] with the captured instruction; an entry with its valid bit clear never matches.
REQ-019 SEARCH match: load out_data={1'b1, zero-fill, idx}, go to EMIT.
REQ-020 SEARCH, no match, idx==DICT_SIZE-1: load out_data={1'b0, instr}, go to EMIT.
REQ-021 SEARCH, otherwise: idx increments, state stays SEARCH.
REQ-022 Latency: accept at edge T, hit at index k -> out_valid high after edge T+k+1; miss -> after edge T+DICT_SIZE.
REQ-023 Duplicate dictionary values: the lowest matching index SHALL win.
REQ-024 EMIT: out_valid=1; out_data held stable until out_valid&&out_ready; on handshake go to IDLE and increment hit_count or miss_count.
REQ-025 in_ready SHALL be 0 in SEARCH and EMIT; no new accept in the handshake cycle (one instruction in flight).
REQ-026 Dictionary write in IDLE: writes dict[dict_addr] and sets its valid bit.
REQ-027 Dictionary write outside IDLE: SHALL be dropped.
REQ-028 Write and accept in the same IDLE cycle: the write SHALL be visible to that search.
REQ-029 Counters SHALL wrap from 16'hFFFF to 0.
REQ-030 Outputs SHALL be registered or decoded from state only; no combinational path from in_* to out_*.

Reset
REQ-031 Reset SHALL take effect asynchronously: state=IDLE, idx=0, all dictionary valid bits=0, out_valid=0, out_data=0, hit_count=0, miss_count=0; in_ready=1 once in IDLE.
REQ-032 Reset during SEARCH or EMIT SHALL abandon the instruction; no token is emitted after release.
REQ-033 Dictionary data storage need not be reset; only the valid bits are.

Structure
REQ-034 Shared package compress_pkg SHALL hold the state enum typedef and the HIT_BIT position constant.
REQ-035 Equality check SHALL use one instance of the existing comparator module (WIDTH-bit).
REQ-036 Expected implementation size is 120-400 lines of RTL.

Verification
REQ-037 Reset, then 16 idle cycles -> in_ready=1, out_valid=0, both counters 0.
REQ-038 Write dict[3]=32'hE3A00001, send 32'hE3A00001 -> out_data=33'h1_00000003 after edge T+4; hit_count=1 after handshake.
REQ-039 Send 32'hDEADBEEF with an empty dictionary -> out_data=33'h0_DEADBEEF after edge T+16; miss_count=1.
REQ-040 dict[2]=dict[9]=32'h12345678, send that value -> index 2 emitted; then out_ready=0 for 5 cycles -> out_data stable, in_ready=0 throughout.
REQ-041 dict_we to addr 5 during SEARCH, then send the written value -> miss token (write dropped).
REQ-042 Assert reset at edge T+3 of a search -> out_valid stays 0 after release, dictionary valid bits cleared.
